// File: rtl/gate_array_seq_if.sv
// Handshake bundle for gate_array_seq: operand/op input channel and
// registered result channel, each with its own valid/ready pair.
interface gate_array_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_parity;
  logic [CNT_W-1:0] beats;
  logic             out_valid;
  logic             out_ready;

  // Producer/consumer side that drives operands and accepts results
  modport master (
    output a, b, op, acc_mode, in_valid, in_last, out_ready,
    input  in_ready, y, y_zero, y_parity, beats, out_valid
  );

  // Gate unit side
  modport slave (
    input  a, b, op, acc_mode, in_valid, in_last, out_ready,
    output in_ready, y, y_zero, y_parity, beats, out_valid
  );
endinterface

// File: rtl/gate_array_seq.sv
// WIDTH-bit registered bitwise gate unit. In single mode every accepted
// beat produces one result; in accumulate mode a burst is folded left to
// right through the gate latched on the first beat, and one result is
// emitted when the last beat arrives.
module gate_array_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  gate_array_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       op_q, op_next;
  logic             mode_q, mode_next;
  logic             load_out;
  logic             accept;
  logic [WIDTH-1:0] y_q;
  logic             y_zero_q;
  logic             y_parity_q;
  logic [CNT_W-1:0] beats_q;

  // Selected bitwise gate; NOT/BUF look only at the first operand
  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = x ^ z;
      3'd3:    r = ~(x & z);
      3'd4:    r = ~(x | z);
      3'd5:    r = ~(x ^ z);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // A held result blocks new beats unless it is being consumed this cycle
  assign bus.in_ready  = (state != HOLD) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.y         = y_q;
  assign bus.y_zero    = y_zero_q;
  assign bus.y_parity  = y_parity_q;
  assign bus.beats     = beats_q;

  // Next-state, accumulator and counter update
  always_comb begin
    next_state = state;
    acc_next   = acc;
    count_next = count;
    op_next    = op_q;
    mode_next  = mode_q;
    load_out   = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          op_next    = bus.op;
          mode_next  = bus.acc_mode;
          acc_next   = gate_f(bus.op, bus.a, bus.b);
          count_next = CNT_W'(1);
          if (!bus.acc_mode || bus.in_last) begin
            next_state = HOLD;
            load_out   = 1'b1;
          end else begin
            next_state = ACC;
          end
        end else if (state == HOLD && bus.out_ready) begin
          next_state = IDLE;
        end
      end
      ACC: begin
        if (accept) begin
          acc_next   = gate_f(op_q, acc, bus.a);
          count_next = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
          // Only an accumulate burst can sit in ACC, so the latched mode
          // merely guards against ever stalling here in single mode.
          if (bus.in_last || !mode_q) begin
            next_state = HOLD;
            load_out   = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      op_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= next_state;
      acc    <= acc_next;
      count  <= count_next;
      op_q   <= op_next;
      mode_q <= mode_next;
    end
  end

  // Result registers, captured only when a result enters HOLD so they stay
  // stable through backpressure and keep their value after delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      y_zero_q   <= 1'b1;
      y_parity_q <= 1'b0;
      beats_q    <= '0;
    end else if (load_out) begin
      y_q        <= acc_next;
      y_zero_q   <= (acc_next == '0);
      y_parity_q <= ^acc_next;
      beats_q    <= count_next;
    end
  end

endmodule

// File: tb/tb_gate_array_seq.sv
// Directed bench for gate_array_seq: a full-width instance for the main
// scenarios and a CNT_W=2 instance for counter saturation. Expected
// results are queued when stimulus is driven and checked on delivery.
module tb_gate_array_seq;

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic [7:0] beats;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;
  exp_t q1[$];
  exp_t q2[$];

  gate_array_seq_if #(.WIDTH(8), .CNT_W(8)) bus1();
  gate_array_seq_if #(.WIDTH(8), .CNT_W(2)) bus2();

  gate_array_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  gate_array_seq #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] op,
                               input logic mode, input logic last);
    bus1.in_valid = v;
    bus1.a        = a;
    bus1.b        = b;
    bus1.op       = op;
    bus1.acc_mode = mode;
    bus1.in_last  = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] y, input logic [7:0] n);
    exp_t e;
    e.y      = y;
    e.zero   = (y == 8'h00);
    e.parity = ^y;
    e.beats  = n;
    return e;
  endfunction

  // Scoreboard for the full-width instance: every delivery must match the
  // oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      checkOutput("sb1_expected_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        checkOutput("sb1_y", 32'(bus1.y), 32'(e.y));
        checkOutput("sb1_y_zero", 32'(bus1.y_zero), 32'(e.zero));
        checkOutput("sb1_y_parity", 32'(bus1.y_parity), 32'(e.parity));
        checkOutput("sb1_beats", 32'(bus1.beats), 32'(e.beats));
      end
    end
  end

  // Scoreboard for the saturating-counter instance
  always @(negedge clk) begin
    if (!rst && bus2.out_valid && bus2.out_ready) begin
      checkOutput("sb2_expected_pending", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        exp_t e;
        e = q2.pop_front();
        checkOutput("sb2_y", 32'(bus2.y), 32'(e.y));
        checkOutput("sb2_y_parity", 32'(bus2.y_parity), 32'(e.parity));
        checkOutput("sb2_beats", 32'(bus2.beats), 32'(e.beats));
      end
    end
  end

  // Directed test sequence
  initial begin
    logic [7:0] sa[5];
    logic [7:0] sb[5];
    logic [2:0] sop[5];
    logic [7:0] sy[5];
    sa  = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hA5};
    sb  = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00};
    sop = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    sy  = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h5A};
    tests_run = 0;
    fails     = 0;

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.a         = 8'h00;
    bus2.b         = 8'h00;
    bus2.op        = 3'd0;
    bus2.acc_mode  = 1'b0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset state
    #1;
    checkOutput("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    checkOutput("rst_y", 32'(bus1.y), 32'd0);
    checkOutput("rst_y_zero", 32'(bus1.y_zero), 32'd1);
    checkOutput("rst_y_parity", 32'(bus1.y_parity), 32'd0);
    checkOutput("rst_beats", 32'(bus1.beats), 32'd0);
    checkOutput("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    #12;
    rst = 1'b0;
    step();

    // Single mode, back-to-back beats at full throughput
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, sa[i], sb[i], sop[i], 1'b0, 1'b0);
      q1.push_back(mk(sy[i], 8'd1));
      checkOutput("single_in_ready", 32'(bus1.in_ready), 32'd1);
      step();
      checkOutput("single_out_valid", 32'(bus1.out_valid), 32'd1);
      checkOutput("single_y_direct", 32'(bus1.y), 32'(sy[i]));
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    checkOutput("single_idle_after", 32'(bus1.out_valid), 32'd0);
    checkOutput("single_y_held", 32'(bus1.y), 32'h5A);

    // XOR accumulate burst
    applyStimulus(1'b1, 8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
    step();
    checkOutput("xor_acc_no_valid0", 32'(bus1.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h04, 8'hEE, 3'd0, 1'b0, 1'b0);
    step();
    checkOutput("xor_acc_no_valid1", 32'(bus1.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h08, 8'hEE, 3'd0, 1'b0, 1'b0);
    step();
    checkOutput("xor_acc_no_valid2", 32'(bus1.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h80, 8'hEE, 3'd0, 1'b0, 1'b1);
    q1.push_back(mk(8'h8F, 8'd4));
    step();
    checkOutput("xor_acc_valid", 32'(bus1.out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();

    // AND accumulate burst with op changed mid-burst
    applyStimulus(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 8'hF0, 8'hFF, 3'd1, 1'b1, 1'b1);
    q1.push_back(mk(8'h00, 8'd2));
    step();
    checkOutput("and_acc_y_zero", 32'(bus1.y_zero), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();

    // Backpressure: hold a result while a new beat waits
    bus1.out_ready = 1'b0;
    applyStimulus(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, 1'b0);
    q1.push_back(mk(8'h26, 8'd1));
    step();
    applyStimulus(1'b1, 8'h55, 8'h0F, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(bus1.out_valid), 32'd1);
      checkOutput("bp_y_stable", 32'(bus1.y), 32'h26);
      step();
    end
    bus1.out_ready = 1'b1;
    q1.push_back(mk(8'h05, 8'd1));
    step();
    checkOutput("bp_new_result", 32'(bus1.y), 32'h05);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();

    // Counter saturation on the CNT_W=2 instance: six-beat OR burst
    bus2.acc_mode = 1'b1;
    bus2.op       = 3'd1;
    bus2.in_valid = 1'b1;
    bus2.a        = 8'h01;
    bus2.b        = 8'h02;
    step();
    for (int i = 0; i < 5; i++) begin
      bus2.a       = 8'h04 << i;
      bus2.in_last = (i == 4);
      if (i == 4) q2.push_back(mk(8'h7F, 8'd3));
      step();
    end
    checkOutput("sat_out_valid", 32'(bus2.out_valid), 32'd1);
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    step();

    // Asynchronous reset in the middle of a burst
    applyStimulus(1'b1, 8'h11, 8'h22, 3'd2, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 8'h33, 8'h00, 3'd2, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(bus1.out_valid), 32'd0);
    checkOutput("arst_y", 32'(bus1.y), 32'd0);
    checkOutput("arst_y_zero", 32'(bus1.y_zero), 32'd1);
    checkOutput("arst_beats", 32'(bus1.beats), 32'd0);
    #2;
    rst = 1'b0;
    step();
    applyStimulus(1'b1, 8'h0F, 8'h0F, 3'd5, 1'b0, 1'b0);
    q1.push_back(mk(8'hFF, 8'd1));
    step();
    checkOutput("post_rst_valid", 32'(bus1.out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    step();

    // Every queued expectation must have been delivered
    checkOutput("sb1_drained", 32'(q1.size()), 32'd0);
    checkOutput("sb2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
